// File: rtl/qam16_in_buff.sv
// -----------------------------------------------------------------------------
// qam16_in_buff
// Transmit-side burst buffer in front of the QAM16 mapper. It collects one
// OFDM burst of payload bytes into a BUFF_W-bit store while in FILL. In DRAIN
// it streams the burst out as 4-bit QAM16 symbols under a valid/ready
// handshake. The first byte received goes out first, high nibble before low.
//
// Optional feature macro: QAM16_IN_BUFF_SYMFLAG_EN
//   When this macro is defined, the block adds the ports sym_start/sym_last
//   and a subcarrier counter that marks OFDM symbol boundaries.
//
// Ports
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   tx_done     in   1  synchronous flush/restart, highest priority
//   din         in   8  payload byte
//   din_valid   in   1  din is valid
//   din_ready   out  1  a byte is accepted this cycle (FILL)
//   dout        out  4  QAM16 symbol, top nibble of the store
//   dout_valid  out  1  dout is valid (DRAIN)
//   dout_ready  in   1  the mapper takes dout this cycle
//   buff_full   out  1  burst fully loaded (DRAIN)
//   frame_done  out  1  one-cycle pulse after the last symbol transfers
//   sym_start   out  1  (SYMFLAG) first nibble of an OFDM symbol
//   sym_last    out  1  (SYMFLAG) last nibble of an OFDM symbol
// -----------------------------------------------------------------------------
module qam16_in_buff #(
    parameter int ACTIVE_SUBCARR = 28,
    parameter int SYMBOL_NUM     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_done,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [3:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       buff_full,
    output logic       frame_done
`ifdef QAM16_IN_BUFF_SYMFLAG_EN
    ,
    output logic       sym_start,
    output logic       sym_last
`endif
);

    localparam int NIB_TOTAL  = ACTIVE_SUBCARR * SYMBOL_NUM;
    localparam int BYTE_TOTAL = NIB_TOTAL / 2;
    localparam int BUFF_W     = 4 * NIB_TOTAL;
    localparam int BYTE_CW    = $clog2(BYTE_TOTAL);
    localparam int NIB_CW     = $clog2(NIB_TOTAL);

    localparam logic [BYTE_CW-1:0] LAST_BYTE = BYTE_CW'(BYTE_TOTAL - 1);
    localparam logic [NIB_CW-1:0]  LAST_NIB  = NIB_CW'(NIB_TOTAL - 1);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e              state_q,      state_d;
    logic [BUFF_W-1:0]   store_q,      store_d;
    logic [BYTE_CW-1:0]  byte_cnt_q,   byte_cnt_d;
    logic [NIB_CW-1:0]   nib_cnt_q,    nib_cnt_d;
    logic                frame_done_q, frame_done_d;

`ifdef QAM16_IN_BUFF_SYMFLAG_EN
    localparam int SC_CW = $clog2(ACTIVE_SUBCARR);
    localparam logic [SC_CW-1:0] LAST_SC = SC_CW'(ACTIVE_SUBCARR - 1);

    logic [SC_CW-1:0]    sc_cnt_q,     sc_cnt_d;
`endif

    // Next-state logic for the FSM, the store and the counters. tx_done dominates.
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        byte_cnt_d   = byte_cnt_q;
        nib_cnt_d    = nib_cnt_q;
        frame_done_d = 1'b0;
`ifdef QAM16_IN_BUFF_SYMFLAG_EN
        sc_cnt_d     = sc_cnt_q;
`endif
        if (tx_done) begin
            state_d    = ST_FILL;
            store_d    = '0;
            byte_cnt_d = '0;
            nib_cnt_d  = '0;
`ifdef QAM16_IN_BUFF_SYMFLAG_EN
            sc_cnt_d   = '0;
`endif
        end else begin
            case (state_q)
                ST_FILL: begin
                    // din_ready is 1 throughout FILL, so din_valid alone qualifies.
                    if (din_valid) begin
                        store_d = {store_q[BUFF_W-9:0], din};
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d = '0;
                            state_d    = ST_DRAIN;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BYTE_CW'(1);
                        end
                    end else begin
                        store_d = store_q;
                    end
                end
                ST_DRAIN: begin
                    // dout_valid is 1 throughout DRAIN, so dout_ready alone qualifies.
                    if (dout_ready) begin
                        store_d = {store_q[BUFF_W-5:0], 4'h0};
                        if (nib_cnt_q == LAST_NIB) begin
                            nib_cnt_d    = '0;
                            state_d      = ST_FILL;
                            frame_done_d = 1'b1;
`ifdef QAM16_IN_BUFF_SYMFLAG_EN
                            sc_cnt_d     = '0;
`endif
                        end else begin
                            nib_cnt_d = nib_cnt_q + NIB_CW'(1);
`ifdef QAM16_IN_BUFF_SYMFLAG_EN
                            if (sc_cnt_q == LAST_SC) begin
                                sc_cnt_d = '0;
                            end else begin
                                sc_cnt_d = sc_cnt_q + SC_CW'(1);
                            end
`endif
                        end
                    end else begin
                        store_d = store_q;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end
    end

    // State, store and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            store_q      <= '0;
            byte_cnt_q   <= '0;
            nib_cnt_q    <= '0;
            frame_done_q <= 1'b0;
`ifdef QAM16_IN_BUFF_SYMFLAG_EN
            sc_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            byte_cnt_q   <= byte_cnt_d;
            nib_cnt_q    <= nib_cnt_d;
            frame_done_q <= frame_done_d;
`ifdef QAM16_IN_BUFF_SYMFLAG_EN
            sc_cnt_q     <= sc_cnt_d;
`endif
        end
    end

    // Handshake flags decode straight from the state register. The oldest
    // nibble always sits at the top of the store because bytes shift in at the
    // bottom and nibbles shift out at the top.
    assign din_ready  = (state_q == ST_FILL);
    assign dout_valid = (state_q == ST_DRAIN);
    assign buff_full  = (state_q == ST_DRAIN);
    assign dout       = store_q[BUFF_W-1 -: 4];
    assign frame_done = frame_done_q;

`ifdef QAM16_IN_BUFF_SYMFLAG_EN
    assign sym_start  = (state_q == ST_DRAIN) && (sc_cnt_q == '0);
    assign sym_last   = (state_q == ST_DRAIN) && (sc_cnt_q == LAST_SC);
`endif

endmodule

// File: doc/qam16_in_buff.md
# qam16_in_buff

Transmit-side frame buffer placed in front of the QAM16 mapper. It accepts one OFDM burst of payload as bytes and holds it in a 896-bit store. It then streams the burst out as 4-bit QAM16 symbols, one per active subcarrier, to the mapper under a valid/ready handshake. It is the transmit-path counterpart of the demapper's output buffer, which packs nibbles into a burst and streams bits out.

## Interface
Parameters:
- `ACTIVE_SUBCARR`, default 28: active OFDM subcarriers per symbol.
- `SYMBOL_NUM`, default 8: OFDM data symbols per burst.
- Derived values, not overridable:
  - `NIB_TOTAL` = ACTIVE_SUBCARR*SYMBOL_NUM = 224.
  - `BYTE_TOTAL` = NIB_TOTAL/2 = 112.
  - `BUFF_W` = 4*NIB_TOTAL = 896.

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `tx_done`, in, 1: synchronous flush/restart.
- `din`, in, 8: payload byte.
- `din_valid`, in, 1: `din` is valid.
- `din_ready`, out, 1: buffer accepts a byte this cycle.
- `dout`, out, 4: QAM16 symbol to the mapper.
- `dout_valid`, out, 1: `dout` is valid.
- `dout_ready`, in, 1: the mapper takes `dout` this cycle.
- `buff_full`, out, 1: burst fully loaded; high throughout the DRAIN state.
- `frame_done`, out, 1: one-cycle pulse after the last symbol transfers.
- `sym_start`, out, 1: present only with SYMFLAG. High with the first nibble of each OFDM symbol.
- `sym_last`, out, 1: present only with SYMFLAG. High with the last nibble of each OFDM symbol.

## Operation
- Two-state FSM, FILL and DRAIN. The state resets to FILL.
- Byte counter: 7 bits, range 0..111. Nibble counter: 8 bits, range 0..223. Subcarrier counter: 5 bits, range 0..27.
- FILL state:
  - `din_ready`=1 and `dout_valid`=0.
  - A byte is accepted when `din_valid`&&`din_ready`. The store shifts left by 8 and the byte is loaded into bits [7:0]; the byte counter increments.
  - On acceptance of byte 112 (counter = 111), the byte counter clears and the FSM goes to DRAIN.
- DRAIN state:
  - `din_ready`=0; `din_valid` is ignored.
  - `dout_valid`=1 and `buff_full`=1.
  - `dout` = store[895:892], taken combinationally from the store.
  - A nibble transfers when `dout_valid`&&`dout_ready`. The store shifts left by 4, the nibble counter increments, and the subcarrier counter increments, wrapping 27->0.
  - While `dout_ready`=0, `dout` and all counters hold.
- Output order: the first byte received is sent first, high nibble before low nibble. Byte k, bits [7:4], is nibble 2k; byte k, bits [3:0], is nibble 2k+1.
- Last-nibble transfer (nibble counter = 223):
  - Both counters clear and the FSM returns to FILL.
  - `frame_done` is 1 on the next cycle only.
  - The store content afterwards is don't-care; `dout` is only meaningful while `dout_valid`=1.
- `tx_done`:
  - Has priority over every other event in any state.
  - On the next edge: FSM to FILL, all counters 0, `frame_done` 0, store cleared to 0.
  - A byte or nibble presented in the same cycle as `tx_done` is not transferred.
- Asynchronous reset, applied at any time including mid-burst: same effect as `tx_done`, applied immediately. A partial burst is discarded.
- Reset values of outputs:
  - `din_ready`=1, since it is decoded from state FILL.
  - `dout`=0, `dout_valid`=0, `buff_full`=0, `frame_done`=0, `sym_start`=0, `sym_last`=0.

## Timing
- No bubble on input: one byte per cycle is accepted while `din_valid` is held high in FILL.
- Fill-to-drain: when byte 112 is accepted at edge N, `dout_valid`=1 with nibble 0 in the cycle after edge N.
- No bubble on output: with `dout_ready` held high, the 224 nibbles take 224 consecutive cycles.
- Drain-to-fill: the last nibble transfers at edge M. `din_ready`=1 and `frame_done`=1 in the cycle after M.
- Minimum burst period with both sides always ready: 112 + 224 = 336 cycles.

## Configuration
- Macro: `QAM16_IN_BUFF_SYMFLAG_EN`.
- When defined:
  - Ports `sym_start` and `sym_last` exist.
  - `sym_start` = `dout_valid` && subcarrier counter = 0.
  - `sym_last` = `dout_valid` && subcarrier counter = ACTIVE_SUBCARR-1.
  - Both are combinational and qualified like `dout`, and both hold while `dout_ready`=0.
- When undefined:
  - The ports and the subcarrier counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then 112 bytes 0x00..0x6F with `din_valid` continuous and `dout_ready`=1:
  - `dout_valid` rises the cycle after byte 112 is accepted.
  - `dout` sequence is 0,0,0,1,0,2,...,6,F over 224 consecutive cycles.
  - `frame_done` pulses once, and `din_ready` returns to 1.
- Random `din_valid` gaps and random `dout_ready` stalls: the output nibble sequence is identical to the first scenario. No byte is accepted while `buff_full`=1, and `dout` is stable while stalled.
- Assert `tx_done` after 50 bytes, then send a fresh 112-byte burst 0xA5 repeated: output is A,5 alternating 112 times. No residue from the first 50 bytes appears.
- Assert `rst_n` low for 1 cycle in the middle of DRAIN (nibble 100): `dout_valid`=0 immediately and `din_ready`=1. The next full burst drains correctly.
- `tx_done` and `din_valid` both high on byte 112: the byte is rejected, the FSM stays in FILL, and the byte counter is 0.
- With SYMFLAG: `sym_start` is high on nibbles 0, 28, ..., 196 and `sym_last` on nibbles 27, 55, ..., 223, for 8 of each per burst. Without SYMFLAG: the design elaborates without those ports.
